// File: rtl/me_move_ctrl_pkg.sv
// Shared craft-movement definitions: direction codes and step defaults.
// Direction codes double as bit indices into the key/blocked vectors.
package me_move_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int STEPS_DEFAULT = 2;

    function automatic logic [1:0] vert_dir(input logic [3:0] k);
        return k[DIR_UP] ? DIR_UP : DIR_DOWN;
    endfunction

    function automatic logic [1:0] horiz_dir(input logic [3:0] k);
        return k[DIR_RIGHT] ? DIR_RIGHT : DIR_LEFT;
    endfunction

    function automatic logic axis_on(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/me_move_ctrl_if.sv
// Step handshake between the movement controller and the craft block.
interface me_move_ctrl_if;

    logic       move_en_o;
    logic [1:0] direct_o;
    logic       moving_i;

    modport master (
        output move_en_o,
        output direct_o,
        input  moving_i
    );

    modport slave (
        input  move_en_o,
        input  direct_o,
        output moving_i
    );

endinterface

// File: rtl/me_move_ctrl.sv
// Per-frame movement sequencer: turns held keys into single-pixel steps,
// interleaving axes and stopping an axis once the craft reports a wall.
module me_move_ctrl
    import me_move_ctrl_pkg::*;
#(
    parameter int STEPS_PER_FRAME = STEPS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick_i,
    input  logic [3:0]    key_i,
    input  logic          pause_i,
    me_move_ctrl_if.master craft,
    output logic          busy_o,
    output logic [3:0]    blocked_o,
    output logic          overrun_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam logic [3:0] STEP_LD = 4'(STEPS_PER_FRAME);

    logic [1:0] r_state;
    logic [3:0] r_keys;
    logic [3:0] r_vcnt;
    logic [3:0] r_hcnt;
    logic [3:0] r_blocked;
    logic [1:0] r_dir;
    logic       r_last_v;
    logic       r_overrun;

    logic w_accept;
    logic w_kv;
    logic w_kh;
    logic w_v_act;
    logic w_h_act;
    logic w_stop;
    logic w_v_ok;
    logic w_h_ok;
    logic w_pick_v;
    logic w_more;

    assign w_accept = (r_state == S_IDLE) && frame_tick_i && !pause_i;
    assign w_kv     = axis_on(key_i[DIR_UP], key_i[DIR_DOWN]);
    assign w_kh     = axis_on(key_i[DIR_LEFT], key_i[DIR_RIGHT]);
    assign w_v_act  = axis_on(r_keys[DIR_UP], r_keys[DIR_DOWN]);
    assign w_h_act  = axis_on(r_keys[DIR_LEFT], r_keys[DIR_RIGHT]);

    // A wall reported this CHECK must already veto the axis just stepped
    assign w_stop = (r_state == S_CHECK) && !craft.moving_i;

    assign w_v_ok = w_v_act && (r_vcnt != 4'd0)
                  && !r_blocked[DIR_UP] && !r_blocked[DIR_DOWN]
                  && !(w_stop && r_last_v);
    assign w_h_ok = w_h_act && (r_hcnt != 4'd0)
                  && !r_blocked[DIR_LEFT] && !r_blocked[DIR_RIGHT]
                  && !(w_stop && !r_last_v);

    assign w_pick_v = w_v_ok && (!w_h_ok || !r_last_v);
    assign w_more   = (w_v_ok || w_h_ok) && !pause_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_keys    <= 4'b0000;
            r_vcnt    <= 4'd0;
            r_hcnt    <= 4'd0;
            r_blocked <= 4'b0000;
            r_dir     <= DIR_UP;
            r_last_v  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= frame_tick_i && (r_state != S_IDLE);
            unique case (1'b1)
                (r_state == S_IDLE): begin
                    if (w_accept) begin
                        r_keys    <= key_i;
                        r_blocked <= 4'b0000;
                        r_vcnt    <= STEP_LD;
                        r_hcnt    <= STEP_LD;
                        if (w_kv || w_kh) begin
                            r_state  <= S_ISSUE;
                            r_last_v <= w_kv;
                            r_dir    <= w_kv ? vert_dir(key_i)
                                             : horiz_dir(key_i);
                        end
                    end
                end
                (r_state == S_ISSUE): begin
                    r_state <= S_CHECK;
                    if (r_last_v) r_vcnt <= r_vcnt - 4'd1;
                    else          r_hcnt <= r_hcnt - 4'd1;
                end
                (r_state == S_CHECK): begin
                    if (w_stop) r_blocked[r_dir] <= 1'b1;
                    if (w_more) begin
                        r_state  <= S_ISSUE;
                        r_last_v <= w_pick_v;
                        r_dir    <= w_pick_v ? vert_dir(r_keys)
                                             : horiz_dir(r_keys);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign craft.move_en_o = (r_state == S_ISSUE);
    assign craft.direct_o  = r_dir;
    assign busy_o          = (r_state == S_ISSUE) || (r_state == S_CHECK);
    assign blocked_o       = r_blocked;
    assign overrun_o       = r_overrun;

endmodule

// File: tb/tb_me_move_ctrl.sv
// Directed bench for me_move_ctrl: hand-computed per-cycle expectations.
module tb_me_move_ctrl;
    import me_move_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [3:0] key;
    logic       pause;
    logic       busy;
    logic [3:0] blocked;
    logic       overrun;
    int         errors;
    int         checks;

    me_move_ctrl_if u_if ();

    me_move_ctrl #(.STEPS_PER_FRAME(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_i (tick),
        .key_i        (key),
        .pause_i      (pause),
        .craft        (u_if),
        .busy_o       (busy),
        .blocked_o    (blocked),
        .overrun_o    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise tick for one cycle; returns in cycle +1 of the frame
    task automatic pulse_tick(input logic [3:0] k);
        key  = k;
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (u_if.move_en_o !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: en=%b busy=%b ovr=%b required 0 0 0",
                     u_if.move_en_o, busy, overrun);
        end
        checks++;
        if (u_if.direct_o !== DIR_UP || blocked !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dir: dir=%0d blk=%b required 0 0000",
                     u_if.direct_o, blocked);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_axis();
        logic exp_en;
        logic exp_busy;
        u_if.moving_i = 1'b1;
        pulse_tick(4'b0001);
        for (int c = 1; c <= 5; c++) begin
            exp_en   = (c == 1) || (c == 3);
            exp_busy = (c <= 4);
            checks++;
            if (u_if.move_en_o !== exp_en || busy !== exp_busy) begin
                errors++;
                $display("FAIL single_c%0d: en=%b busy=%b required %b %b",
                         c, u_if.move_en_o, busy, exp_en, exp_busy);
            end
            if (exp_en) begin
                checks++;
                if (u_if.direct_o !== DIR_UP) begin
                    errors++;
                    $display("FAIL single_dir_c%0d: got %0d required %0d",
                             c, u_if.direct_o, DIR_UP);
                end
            end
            step();
        end
    endtask

    task automatic test_interleave();
        logic [1:0] exp_dir [4];
        logic       exp_en;
        exp_dir[0] = DIR_UP;
        exp_dir[1] = DIR_RIGHT;
        exp_dir[2] = DIR_UP;
        exp_dir[3] = DIR_RIGHT;
        u_if.moving_i = 1'b1;
        pulse_tick(4'b1001);
        for (int c = 1; c <= 9; c++) begin
            exp_en = (c <= 8) && (c % 2 == 1);
            checks++;
            if (u_if.move_en_o !== exp_en || busy !== (c <= 8)) begin
                errors++;
                $display("FAIL inter_c%0d: en=%b busy=%b required %b %b",
                         c, u_if.move_en_o, busy, exp_en, (c <= 8));
            end
            if (exp_en) begin
                checks++;
                if (u_if.direct_o !== exp_dir[(c - 1) / 2]) begin
                    errors++;
                    $display("FAIL inter_dir_c%0d: got %0d required %0d",
                             c, u_if.direct_o, exp_dir[(c - 1) / 2]);
                end
            end
            step();
        end
        checks++;
        if (blocked !== 4'b0000) begin
            errors++;
            $display("FAIL inter_blk: got %b required 0000", blocked);
        end
    endtask

    task automatic test_cancel_axes();
        int en_cnt;
        int busy_cnt;
        en_cnt   = 0;
        busy_cnt = 0;
        pulse_tick(4'b0011);
        for (int c = 1; c <= 4; c++) begin
            en_cnt   += int'(u_if.move_en_o);
            busy_cnt += int'(busy);
            step();
        end
        checks++;
        if (en_cnt != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL cancel: en_cycles=%0d busy_cycles=%0d required 0 0",
                     en_cnt, busy_cnt);
        end
    endtask

    task automatic test_blocked();
        u_if.moving_i = 1'b0;
        pulse_tick(4'b0100);
        checks++;
        if (u_if.move_en_o !== 1'b1 || u_if.direct_o !== DIR_LEFT) begin
            errors++;
            $display("FAIL blk_issue: en=%b dir=%0d required 1 %0d",
                     u_if.move_en_o, u_if.direct_o, DIR_LEFT);
        end
        step();
        checks++;
        if (busy !== 1'b1 || u_if.move_en_o !== 1'b0) begin
            errors++;
            $display("FAIL blk_check: busy=%b en=%b required 1 0",
                     busy, u_if.move_en_o);
        end
        step();
        u_if.moving_i = 1'b1;
        checks++;
        if (busy !== 1'b0 || u_if.move_en_o !== 1'b0 || blocked !== 4'b0100) begin
            errors++;
            $display("FAIL blk_end: busy=%b en=%b blk=%b required 0 0 0100",
                     busy, u_if.move_en_o, blocked);
        end
        step();
        step();
        checks++;
        if (blocked !== 4'b0100 || u_if.direct_o !== DIR_LEFT) begin
            errors++;
            $display("FAIL blk_hold: blk=%b dir=%0d required 0100 %0d",
                     blocked, u_if.direct_o, DIR_LEFT);
        end
    endtask

    task automatic test_overrun();
        int en_cnt;
        int ovr_cnt;
        en_cnt  = 0;
        ovr_cnt = 0;
        u_if.moving_i = 1'b1;
        pulse_tick(4'b0001);
        checks++;
        if (blocked !== 4'b0000) begin
            errors++;
            $display("FAIL ovr_blkclr: got %b required 0000", blocked);
        end
        for (int c = 1; c <= 8; c++) begin
            tick = (c == 2);
            en_cnt  += int'(u_if.move_en_o);
            ovr_cnt += int'(overrun);
            if (c == 3) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_pulse: got %b required 1", overrun);
                end
            end
            step();
        end
        tick = 1'b0;
        checks++;
        if (en_cnt != 2 || ovr_cnt != 1) begin
            errors++;
            $display("FAIL ovr_counts: steps=%0d ovr=%0d required 2 1",
                     en_cnt, ovr_cnt);
        end
    endtask

    task automatic test_pause();
        int en_cnt;
        en_cnt = 0;
        u_if.moving_i = 1'b1;
        pause = 1'b1;
        pulse_tick(4'b0001);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL pause_idle: busy=%b ovr=%b required 0 0",
                     busy, overrun);
        end
        pause = 1'b0;
        step();
        pulse_tick(4'b1001);
        for (int c = 1; c <= 6; c++) begin
            pause = (c == 2);
            en_cnt += int'(u_if.move_en_o);
            step();
            if (c == 2) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_stop: busy=%b required 0", busy);
                end
            end
        end
        pause = 1'b0;
        checks++;
        if (en_cnt != 1) begin
            errors++;
            $display("FAIL pause_steps: got %0d required 1", en_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic exp_en;
        u_if.moving_i = 1'b1;
        pulse_tick(4'b1000);
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || u_if.move_en_o !== 1'b0 || overrun !== 1'b0
            || blocked !== 4'b0000 || u_if.direct_o !== DIR_UP) begin
            errors++;
            $display("FAIL rstmid: busy=%b en=%b ovr=%b blk=%b dir=%0d required 0 0 0 0000 0",
                     busy, u_if.move_en_o, overrun, blocked, u_if.direct_o);
        end
        step();
        rst_n = 1'b1;
        step();
        pulse_tick(4'b1000);
        for (int c = 1; c <= 5; c++) begin
            exp_en = (c == 1) || (c == 3);
            checks++;
            if (u_if.move_en_o !== exp_en || busy !== (c <= 4)) begin
                errors++;
                $display("FAIL rstnew_c%0d: en=%b busy=%b required %b %b",
                         c, u_if.move_en_o, busy, exp_en, (c <= 4));
            end
            if (exp_en) begin
                checks++;
                if (u_if.direct_o !== DIR_RIGHT) begin
                    errors++;
                    $display("FAIL rstnew_dir_c%0d: got %0d required %0d",
                             c, u_if.direct_o, DIR_RIGHT);
                end
            end
            step();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        tick   = 1'b0;
        key    = 4'b0000;
        pause  = 1'b0;
        u_if.moving_i = 1'b1;
        test_reset();
        test_single_axis();
        test_interleave();
        test_cancel_axes();
        test_blocked();
        test_overrun();
        test_pause();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
